// File: rtl/gpu_pattern_pkg.sv
// Shared definitions for the pattern-row datapath: default geometry and serializer FSM encoding.
package gpu_pattern_pkg;

  localparam int PIXELS_DEF = 8;
  localparam int BPP_DEF    = 2;
  localparam int ROW_W      = PIXELS_DEF * BPP_DEF;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/pattern_row_reverser_m.sv
// Combinational hflip: reverses the order of BPP-wide pixel fields when i_hflip is set.
module pattern_row_reverser_m
  import gpu_pattern_pkg::*;
#(
  parameter int PIXELS = PIXELS_DEF,
  parameter int BPP    = BPP_DEF
) (
  input  logic [PIXELS*BPP-1:0] i_row,
  input  logic                  i_hflip,
  output logic [PIXELS*BPP-1:0] o_row
);

  for (genvar g = 0; g < PIXELS; g++) begin : g_field
    assign o_row[g*BPP +: BPP] = i_hflip ? i_row[(PIXELS-1-g)*BPP +: BPP]
                                         : i_row[g*BPP +: BPP];
  end

endmodule

// File: rtl/pattern_row_serializer_m.sv
// Pattern row to pixel stream serializer with per-row hflip applied on load.
// Optional PATTERN_ROW_SERIALIZER_PRELOAD_EN adds a one-row holding register for bubble-free rows.
module pattern_row_serializer_m
  import gpu_pattern_pkg::*;
#(
  parameter int PIXELS = PIXELS_DEF,
  parameter int BPP    = BPP_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PIXELS*BPP-1:0] in_row,
  input  logic                  in_hflip,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BPP-1:0]        out_pixel,
  output logic                  out_last
);

  localparam int              RW         = PIXELS * BPP;
  localparam int              CW         = $clog2(PIXELS);
  localparam logic [CW-1:0]   LAST_IDX   = CW'(PIXELS - 1);
  localparam logic [CW-1:0]   PENULT_IDX = CW'(PIXELS - 2);

  state_e          r_state;
  state_e          w_state_next;
  logic [RW-1:0]   r_shreg;
  logic [RW-1:0]   w_rev_row;
  logic [CW-1:0]   r_count;
  logic            r_out_last;
  logic            w_in_fire;
  logic            w_last_beat;
  logic            w_load_in;
  logic            w_shift;
`ifdef PATTERN_ROW_SERIALIZER_PRELOAD_EN
  logic            r_hold_valid;
  logic [RW-1:0]   r_hold_row;
  logic            w_load_hold;
  logic            w_capture;
`endif

  pattern_row_reverser_m #(
    .PIXELS (PIXELS),
    .BPP    (BPP)
  ) u_reverser (
    .i_row   (in_row),
    .i_hflip (in_hflip),
    .o_row   (w_rev_row)
  );

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    w_state_next = r_state;
    w_load_in    = 1'b0;
    w_shift      = 1'b0;
`ifdef PATTERN_ROW_SERIALIZER_PRELOAD_EN
    w_load_hold  = 1'b0;
    w_capture    = 1'b0;
    in_ready     = !r_hold_valid;
`else
    in_ready     = (r_state == ST_IDLE);
`endif
    w_in_fire   = in_valid && in_ready;
    w_last_beat = (r_state == ST_SHIFT) && out_ready && (r_count == LAST_IDX);

    case (r_state)
      ST_IDLE: begin
        if (w_in_fire) begin
          w_load_in    = 1'b1;
          w_state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_last_beat) begin
`ifdef PATTERN_ROW_SERIALIZER_PRELOAD_EN
          if (r_hold_valid)   w_load_hold  = 1'b1;
          else if (w_in_fire) w_load_in    = 1'b1;
          else                w_state_next = ST_IDLE;
`else
          w_state_next = ST_IDLE;
`endif
        end else if (out_ready) begin
          w_shift = 1'b1;
        end
`ifdef PATTERN_ROW_SERIALIZER_PRELOAD_EN
        // A row offered mid-row parks in the holding register until the last beat.
        w_capture = w_in_fire && !w_load_in;
`endif
      end
      default: w_state_next = ST_IDLE;
    endcase

    // Flush discards both beats of this cycle; in_ready is left as computed above.
    if (flush) begin
      w_state_next = ST_IDLE;
      w_load_in    = 1'b0;
      w_shift      = 1'b0;
`ifdef PATTERN_ROW_SERIALIZER_PRELOAD_EN
      w_load_hold  = 1'b0;
      w_capture    = 1'b0;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg    <= '0;
      r_count    <= '0;
      r_out_last <= 1'b0;
    end else if (w_state_next == ST_IDLE) begin
      r_count    <= '0;
      r_out_last <= 1'b0;
    end else if (w_load_in) begin
      r_shreg    <= w_rev_row;
      r_count    <= '0;
      r_out_last <= 1'b0;
`ifdef PATTERN_ROW_SERIALIZER_PRELOAD_EN
    end else if (w_load_hold) begin
      r_shreg    <= r_hold_row;
      r_count    <= '0;
      r_out_last <= 1'b0;
`endif
    end else if (w_shift) begin
      r_shreg    <= r_shreg << BPP;
      r_count    <= r_count + 1'b1;
      r_out_last <= (r_count == PENULT_IDX);
    end
  end

`ifdef PATTERN_ROW_SERIALIZER_PRELOAD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_hold_valid <= 1'b0;
    else if (flush)       r_hold_valid <= 1'b0;
    else if (w_capture)   r_hold_valid <= 1'b1;
    else if (w_load_hold) r_hold_valid <= 1'b0;
  end

  // NOTE: the held row is pure data qualified by r_hold_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_capture) r_hold_row <= w_rev_row;
  end
`endif

  assign out_valid = (r_state == ST_SHIFT);
  assign out_pixel = r_shreg[RW-1 -: BPP];
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_pattern_row_serializer_m.sv
// Self-checking bench for pattern_row_serializer_m (default 8x2 and a 5x4 instance).
module tb_pattern_row_serializer_m;
  import gpu_pattern_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [ROW_W-1:0] in_row;
  logic             in_hflip;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_pixel;
  logic             out_last;

  logic             in_valid5;
  logic             in_ready5;
  logic [19:0]      in_row5;
  logic             in_hflip5;
  logic             out_valid5;
  logic [3:0]       out_pixel5;
  logic             out_last5;

  int n_checks = 0;
  int n_errors = 0;

  int exp_q[$];
  int exp5_q[$];
  int obs_q[$];
  int expd_q[$];
  int obs5_q[$];
  int expd5_q[$];
  bit vld_hist[$];
  bit last_in_fire;

  always #5 clk = ~clk;

  pattern_row_serializer_m u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row    (in_row),
    .in_hflip  (in_hflip),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pixel (out_pixel),
    .out_last  (out_last)
  );

  pattern_row_serializer_m #(.PIXELS(5), .BPP(4)) u_dut5 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid5),
    .in_ready  (in_ready5),
    .in_row    (in_row5),
    .in_hflip  (in_hflip5),
    .out_valid (out_valid5),
    .out_ready (1'b1),
    .out_pixel (out_pixel5),
    .out_last  (out_last5)
  );

  // Reference: expected beats of a row, encoded as (last << bpp) | pixel, in emission order.
  function automatic void model_row(input logic [63:0] row, input bit hflip, input int pix,
                                    input int bpp, input bit to_p5);
    for (int i = 0; i < pix; i++) begin
      int idx;
      int val;
      idx = hflip ? pix - 1 - i : i;
      val = int'((row >> (bpp * (pix - 1 - idx))) & ((64'd1 << bpp) - 64'd1));
      if (i == pix - 1) val += (1 << bpp);
      if (to_p5) exp5_q.push_back(val);
      else       exp_q.push_back(val);
    end
  endfunction

  // One clock: record handshakes seen with the current inputs, then advance to the next negedge.
  task automatic tick();
    int e;
    #1;
    last_in_fire = 1'b0;
    vld_hist.push_back(out_valid);
    if (flush) begin
      exp_q.delete();
      exp5_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        obs_q.push_back(int'({out_last, out_pixel}));
        expd_q.push_back(e);
      end
      if (in_valid && in_ready) begin
        model_row(64'(in_row), in_hflip, 8, 2, 1'b0);
        last_in_fire = 1'b1;
      end
      if (out_valid5) begin
        e = (exp5_q.size() > 0) ? exp5_q.pop_front() : -1;
        obs5_q.push_back(int'({out_last5, out_pixel5}));
        expd5_q.push_back(e);
      end
      if (in_valid5 && in_ready5) model_row(64'(in_row5), in_hflip5, 5, 4, 1'b1);
    end
    @(negedge clk);
  endtask

  task automatic clear_logs();
    obs_q.delete();
    expd_q.delete();
    obs5_q.delete();
    expd5_q.delete();
    vld_hist.delete();
  endtask

  task automatic run_until_beats(input int n, input int budget, input string tag);
    int b;
    b = 0;
    while (obs_q.size() < n && b < budget) begin
      tick();
      b++;
    end
    if (obs_q.size() < n) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: got %0d beats, required %0d", tag, obs_q.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_row = '0; in_hflip = 1'b0; out_ready = 1'b1;
    in_valid5 = 1'b0; in_row5 = '0; in_hflip5 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({out_valid, out_last, out_pixel, in_ready, out_valid5} !== 6'b000010) begin
      n_errors++;
      $display("FAIL reset_outputs: got v=%b l=%b p=%0d rdy=%b v5=%b, required 0 0 0 1 0",
               out_valid, out_last, out_pixel, in_ready, out_valid5);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_row(input bit hflip);
    int kp[8];
    clear_logs();
    for (int i = 0; i < 8; i++) kp[i] = hflip ? (i % 4) : 3 - (i % 4);
    in_row = 16'hE4E4; in_hflip = hflip; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    run_until_beats(8, 40, "single_row");
    for (int i = 0; i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== (kp[i] | ((i == 7) ? 4 : 0)) || obs_q[i] !== expd_q[i]) begin
        n_errors++;
        $display("FAIL single_row_h%0d_beat%0d: got %0d, required %0d", hflip, i, obs_q[i],
                 kp[i] | ((i == 7) ? 4 : 0));
      end
    end
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL single_row_end: got in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] rows[2];
    int sent, b, first, last, gaps, ones;
    clear_logs();
    rows[0] = 16'($urandom); rows[1] = 16'($urandom);
    sent = 0; b = 0; out_ready = 1'b1;
    while (obs_q.size() < 16 && b < 60) begin
      in_valid = (sent < 2);
      in_row   = rows[sent % 2];
      in_hflip = sent[0];
      tick();
      if (last_in_fire) sent++;
      b++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (obs_q.size() != 16) begin
      n_errors++;
      $display("FAIL b2b_beats: got %0d, required 16", obs_q.size());
    end
    for (int i = 0; i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== expd_q[i]) begin
        n_errors++;
        $display("FAIL b2b_beat%0d: got %0d, required %0d", i, obs_q[i], expd_q[i]);
      end
    end
    first = -1; last = -1; gaps = 0; ones = 0;
    for (int i = 0; i < vld_hist.size(); i++) if (vld_hist[i]) begin
      if (first < 0) first = i;
      last = i;
      ones++;
    end
    gaps = (first < 0) ? -1 : (last - first + 1 - ones);
    n_checks++;
`ifdef PATTERN_ROW_SERIALIZER_PRELOAD_EN
    if (gaps !== 0) begin
      n_errors++;
      $display("FAIL b2b_bubble: got %0d dead cycles, required 0", gaps);
    end
`else
    if (gaps !== 1) begin
      n_errors++;
      $display("FAIL b2b_bubble: got %0d dead cycles, required 1", gaps);
    end
`endif
  endtask

  task automatic test_stall();
    logic [1:0] held_pix;
    logic       held_last;
    int c;
    clear_logs();
    in_row = 16'($urandom); in_hflip = 1'($urandom); in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    c = 0;
    while (obs_q.size() < 8 && c < 40) begin
      out_ready = !(c == 2 || c == 3);
      if (c == 2) begin
        held_pix = out_pixel; held_last = out_last;
      end
      if (c == 3 || c == 4) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_pixel !== held_pix || out_last !== held_last) begin
          n_errors++;
          $display("FAIL stall_hold_c%0d: got v=%b p=%0d l=%b, required 1 %0d %b",
                   c, out_valid, out_pixel, out_last, held_pix, held_last);
        end
      end
      tick();
      c++;
    end
    out_ready = 1'b1;
    n_checks++;
    if (obs_q.size() != 8 || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL stall_count: got %0d beats %0d pending, required 8 0", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== expd_q[i]) begin
        n_errors++;
        $display("FAIL stall_beat%0d: got %0d, required %0d", i, obs_q[i], expd_q[i]);
      end
    end
  endtask

  task automatic test_flush();
    clear_logs();
    in_row = 16'($urandom); in_hflip = 1'($urandom); in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    run_until_beats(4, 30, "flush");
    flush = 1'b1; in_valid = 1'b1; in_row = 16'($urandom);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_outputs: got v=%b l=%b, required 0 0", out_valid, out_last);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL flush_new_row_taken: got v=%b, required 0", out_valid);
    end
    for (int i = 0; i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== expd_q[i]) begin
        n_errors++;
        $display("FAIL flush_beat%0d: got %0d, required %0d", i, obs_q[i], expd_q[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    clear_logs();
    in_row = 16'hFFFF; in_hflip = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, out_last, out_pixel} !== 4'b0000) begin
      n_errors++;
      $display("FAIL async_reset: got v=%b l=%b p=%0d, required 0 0 0", out_valid, out_last, out_pixel);
    end
    rst_n = 1'b1;
    exp_q.delete();
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL async_reset_after: got v=%b rdy=%b, required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_random();
    logic [15:0] rows[16];
    bit          flips[16];
    int sent, b;
    clear_logs();
    for (int i = 0; i < 16; i++) begin
      rows[i] = 16'($urandom); flips[i] = 1'($urandom);
    end
    sent = 0; b = 0;
    while ((sent < 16 || obs_q.size() < 128) && b < 2000) begin
      in_valid  = (sent < 16) && ($urandom_range(0, 3) != 0);
      in_row    = rows[sent % 16];
      in_hflip  = flips[sent % 16];
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (last_in_fire) sent++;
      b++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_checks++;
    if (obs_q.size() != 128) begin
      n_errors++;
      $display("FAIL random_count: got %0d beats, required 128", obs_q.size());
    end
    for (int i = 0; i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== expd_q[i]) begin
        n_errors++;
        $display("FAIL random_beat%0d: got %0d, required %0d", i, obs_q[i], expd_q[i]);
      end
    end
  endtask

  task automatic test_p5();
    int b;
    clear_logs();
    in_row5 = 20'h12345; in_hflip5 = 1'b1; in_valid5 = 1'b1;
    tick();
    in_valid5 = 1'b0;
    b = 0;
    while (obs5_q.size() < 5 && b < 30) begin
      tick();
      b++;
    end
    n_checks++;
    if (obs5_q.size() != 5) begin
      n_errors++;
      $display("FAIL p5_count: got %0d beats, required 5", obs5_q.size());
    end
    for (int i = 0; i < obs5_q.size(); i++) begin
      n_checks++;
      if (obs5_q[i] !== ((5 - i) | ((i == 4) ? 16 : 0)) || obs5_q[i] !== expd5_q[i]) begin
        n_errors++;
        $display("FAIL p5_beat%0d: got %0d, required %0d", i, obs5_q[i],
                 (5 - i) | ((i == 4) ? 16 : 0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_row(1'b0);
    test_single_row(1'b1);
    test_back_to_back();
    test_stall();
    test_flush();
    test_async_reset();
    test_random();
    test_p5();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
